// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 64-bit memory port between instruction fetch and data access.
// Aligns store lanes/strobes, extends load data, and flags misaligned requests without a bus cycle.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              ires_valid,
    output logic [31:0]       ires_instr,
    output logic              ires_err,
    input  logic              dreq_valid,
    input  logic              dreq_we,
    input  logic [2:0]        dreq_info,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [63:0]       dreq_wdata,
    output logic              dres_valid,
    output logic [63:0]       dres_rdata,
    output logic              dres_err,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [7:0]        bus_strb,
    output logic [63:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [63:0]       bus_rdata
);

    typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} state_t;

    state_t            r_state, w_nxt_state;
    logic              r_last_d, w_nxt_last_d;
    logic              r_is_d, w_nxt_is_d;
    logic              r_we, w_nxt_we;
    logic [2:0]        r_info, w_nxt_info;
    logic [2:0]        r_off, w_nxt_off;

    logic              r_bus_valid, w_nxt_bus_valid;
    logic [ADDR_W-1:0] r_bus_addr, w_nxt_bus_addr;
    logic              r_bus_we, w_nxt_bus_we;
    logic [7:0]        r_bus_strb, w_nxt_bus_strb;
    logic [63:0]       r_bus_wdata, w_nxt_bus_wdata;
    logic              r_ires_valid, w_nxt_ires_valid;
    logic [31:0]       r_ires_instr, w_nxt_ires_instr;
    logic              r_ires_err, w_nxt_ires_err;
    logic              r_dres_valid, w_nxt_dres_valid;
    logic [63:0]       r_dres_rdata, w_nxt_dres_rdata;
    logic              r_dres_err, w_nxt_dres_err;

    logic              w_grant_d;
    logic              w_d_misaligned;
    logic [7:0]        w_d_strb_base;

    function automatic logic [63:0] f_load(input logic [63:0] d, input logic [2:0] off,
                                           input logic [2:0] info);
        logic [63:0] s;
        s = d >> {off, 3'b000};
        case (info[1:0])
            2'd0:    f_load = info[2] ? {56'd0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
            2'd1:    f_load = info[2] ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            2'd2:    f_load = info[2] ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: f_load = s;
        endcase
    endfunction

    always_comb begin
        w_d_misaligned = 1'b0;
        w_d_strb_base  = 8'h01;
        case (dreq_info[1:0])
            2'd0: begin w_d_misaligned = 1'b0;             w_d_strb_base = 8'h01; end
            2'd1: begin w_d_misaligned = dreq_addr[0];     w_d_strb_base = 8'h03; end
            2'd2: begin w_d_misaligned = |dreq_addr[1:0];  w_d_strb_base = 8'h0F; end
            default: begin w_d_misaligned = |dreq_addr[2:0]; w_d_strb_base = 8'hFF; end
        endcase
    end

    // On a tie, data wins unless data took the previous grant.
    assign w_grant_d = dreq_valid && (!ireq_valid || !r_last_d);

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_last_d     = r_last_d;
        w_nxt_is_d       = r_is_d;
        w_nxt_we         = r_we;
        w_nxt_info       = r_info;
        w_nxt_off        = r_off;
        w_nxt_bus_valid  = r_bus_valid;
        w_nxt_bus_addr   = r_bus_addr;
        w_nxt_bus_we     = r_bus_we;
        w_nxt_bus_strb   = r_bus_strb;
        w_nxt_bus_wdata  = r_bus_wdata;
        w_nxt_ires_valid = r_ires_valid;
        w_nxt_ires_instr = r_ires_instr;
        w_nxt_ires_err   = r_ires_err;
        w_nxt_dres_valid = r_dres_valid;
        w_nxt_dres_rdata = r_dres_rdata;
        w_nxt_dres_err   = r_dres_err;

        case (r_state)
            IDLE: begin
                if (ireq_valid || dreq_valid) begin
                    w_nxt_last_d = w_grant_d;
                    w_nxt_is_d   = w_grant_d;
                    if (w_grant_d) begin
                        w_nxt_we   = dreq_we;
                        w_nxt_info = dreq_info;
                        w_nxt_off  = dreq_addr[2:0];
                        if (w_d_misaligned) begin
                            w_nxt_state      = RESP;
                            w_nxt_dres_valid = 1'b1;
                            w_nxt_dres_err   = 1'b1;
                            w_nxt_dres_rdata = '0;
                        end else begin
                            w_nxt_state     = DBUS;
                            w_nxt_bus_valid = 1'b1;
                            w_nxt_bus_addr  = {dreq_addr[ADDR_W-1:3], 3'b000};
                            w_nxt_bus_we    = dreq_we;
                            w_nxt_bus_strb  = w_d_strb_base << dreq_addr[2:0];
                            w_nxt_bus_wdata = dreq_wdata << {dreq_addr[2:0], 3'b000};
                        end
                    end else begin
                        w_nxt_we   = 1'b0;
                        w_nxt_info = 3'd2;
                        w_nxt_off  = ireq_addr[2:0];
                        if (|ireq_addr[1:0]) begin
                            w_nxt_state      = RESP;
                            w_nxt_ires_valid = 1'b1;
                            w_nxt_ires_err   = 1'b1;
                            w_nxt_ires_instr = '0;
                        end else begin
                            w_nxt_state     = IBUS;
                            w_nxt_bus_valid = 1'b1;
                            w_nxt_bus_addr  = {ireq_addr[ADDR_W-1:3], 3'b000};
                            w_nxt_bus_we    = 1'b0;
                            w_nxt_bus_strb  = ireq_addr[2] ? 8'hF0 : 8'h0F;
                            w_nxt_bus_wdata = '0;
                        end
                    end
                end
            end
            IBUS, DBUS: begin
                if (bus_ready) begin
                    w_nxt_state     = RESP;
                    w_nxt_bus_valid = 1'b0;
                    w_nxt_bus_addr  = '0;
                    w_nxt_bus_we    = 1'b0;
                    w_nxt_bus_strb  = '0;
                    w_nxt_bus_wdata = '0;
                    if (r_is_d) begin
                        w_nxt_dres_valid = 1'b1;
                        w_nxt_dres_err   = 1'b0;
                        w_nxt_dres_rdata = r_we ? 64'd0 : f_load(bus_rdata, r_off, r_info);
                    end else begin
                        w_nxt_ires_valid = 1'b1;
                        w_nxt_ires_err   = 1'b0;
                        w_nxt_ires_instr = r_off[2] ? bus_rdata[63:32] : bus_rdata[31:0];
                    end
                end
            end
            default: begin
                w_nxt_state      = IDLE;
                w_nxt_ires_valid = 1'b0;
                w_nxt_ires_instr = '0;
                w_nxt_ires_err   = 1'b0;
                w_nxt_dres_valid = 1'b0;
                w_nxt_dres_rdata = '0;
                w_nxt_dres_err   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_d     <= 1'b0;
            r_is_d       <= 1'b0;
            r_we         <= 1'b0;
            r_info       <= '0;
            r_off        <= '0;
            r_bus_valid  <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_we     <= 1'b0;
            r_bus_strb   <= '0;
            r_bus_wdata  <= '0;
            r_ires_valid <= 1'b0;
            r_ires_instr <= '0;
            r_ires_err   <= 1'b0;
            r_dres_valid <= 1'b0;
            r_dres_rdata <= '0;
            r_dres_err   <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_last_d     <= w_nxt_last_d;
            r_is_d       <= w_nxt_is_d;
            r_we         <= w_nxt_we;
            r_info       <= w_nxt_info;
            r_off        <= w_nxt_off;
            r_bus_valid  <= w_nxt_bus_valid;
            r_bus_addr   <= w_nxt_bus_addr;
            r_bus_we     <= w_nxt_bus_we;
            r_bus_strb   <= w_nxt_bus_strb;
            r_bus_wdata  <= w_nxt_bus_wdata;
            r_ires_valid <= w_nxt_ires_valid;
            r_ires_instr <= w_nxt_ires_instr;
            r_ires_err   <= w_nxt_ires_err;
            r_dres_valid <= w_nxt_dres_valid;
            r_dres_rdata <= w_nxt_dres_rdata;
            r_dres_err   <= w_nxt_dres_err;
        end
    end

    assign bus_valid  = r_bus_valid;
    assign bus_addr   = r_bus_addr;
    assign bus_we     = r_bus_we;
    assign bus_strb   = r_bus_strb;
    assign bus_wdata  = r_bus_wdata;
    assign ires_valid = r_ires_valid;
    assign ires_instr = r_ires_instr;
    assign ires_err   = r_ires_err;
    assign dres_valid = r_dres_valid;
    assign dres_rdata = r_dres_rdata;
    assign dres_err   = r_dres_err;

endmodule
